// File: rtl/aes_sched_pkg.sv
// -----------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the AES core scheduler:
//   - sched_state_e : scheduler FSM states
//   - AES_W         : AES block / key width in bits
//   - slice_lo()    : low bit index of requester k inside a packed N*AES_W bus
// -----------------------------------------------------------------------------
package aes_sched_pkg;

    localparam int AES_W = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        RESP = 3'd4
    } sched_state_e;

    // Requester k occupies bits [AES_W*k + AES_W-1 : AES_W*k] of a packed bus.
    function automatic int slice_lo(input int k);
        return k * AES_W;
    endfunction

endpackage

// File: rtl/aes_core_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req_i starting at
// pointer_i and wrapping around; the first set bit wins.
//
// Ports:
//   req_i     in  N      request vector
//   pointer_i in  IDX_W  index to start the search from (0..N-1)
//   enable_i  in  1      when low no grant is produced
//   gnt_o     out N      one-hot grant, or zero when nothing wins
//   index_o   out IDX_W  index of the granted bit (0 when gnt_o is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] pointer_i,
    input  logic             enable_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] index_o
);

    logic found;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        gnt_o   = '0;
        index_o = '0;
        found   = 1'b0;
        if (enable_i) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[(int'(pointer_i) + i) % N]) begin
                    found                              = 1'b1;
                    gnt_o[(int'(pointer_i) + i) % N]   = 1'b1;
                    index_o                            = IDX_W'((int'(pointer_i) + i) % N);
                end
            end
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// -----------------------------------------------------------------------------
// aes_core_scheduler
// Shares one AES core between N_REQ requesters. Jobs (key + plaintext) are
// accepted round-robin, the core is started with a one-cycle load pulse, its
// busy flag is tracked to completion and the captured ciphertext is returned
// to the owning requester over a valid/ready response channel. If the core
// never raises busy within ARM_TIMEOUT cycles of the load, the response is
// returned with rsp_err_o set and zero data.
//
// Optional build macro:
//   AES_SCHED_TRIGGER_EN - adds registered output trigger_o, high while the
//                          core is armed or running (scope trigger).
//
// Ports:
//   clk          in   1          system clock
//   reset_i      in   1          synchronous active-high reset
//   req_valid_i  in   N_REQ      per-requester job valid
//   req_ready_o  out  N_REQ      per-requester job accept (one-hot or zero)
//   req_key_i    in   N_REQ*128  packed keys, requester k at [128k+127:128k]
//   req_data_i   in   N_REQ*128  packed plaintexts, same packing
//   rsp_valid_o  out  N_REQ      result valid to owner (one-hot or zero)
//   rsp_ready_i  in   N_REQ      requester accepts result
//   rsp_data_o   out  128        captured ciphertext
//   rsp_err_o    out  1          core never went busy
//   core_load_o  out  1          core load strobe
//   core_key_o   out  128        core key
//   core_data_o  out  128        core plaintext
//   core_data_i  in   128        core result
//   core_busy_i  in   1          core busy
//   trigger_o    out  1          (AES_SCHED_TRIGGER_EN only) scope trigger
//   grant_id_o   out  ID_W       current owner, valid when not IDLE
// -----------------------------------------------------------------------------
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ARM_TIMEOUT = 4,   // must be >= 2
    parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*AES_W-1:0]   req_key_i,
    input  logic [N_REQ*AES_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [AES_W-1:0]         rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     core_load_o,
    output logic [AES_W-1:0]         core_key_o,
    output logic [AES_W-1:0]         core_data_o,
    input  logic [AES_W-1:0]         core_data_i,
    input  logic                     core_busy_i,
`ifdef AES_SCHED_TRIGGER_EN
    output logic                     trigger_o,
`endif
    output logic [ID_W-1:0]          grant_id_o
);

    localparam int CNT_W = $clog2(ARM_TIMEOUT) + 1;

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [AES_W-1:0] key_q, key_d;
    logic [AES_W-1:0] pt_q, pt_d;
    logic [AES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i     (req_valid_i),
        .pointer_i (ptr_q),
        .enable_i  (state_q == IDLE),
        .gnt_o     (arb_gnt),
        .index_o   (arb_idx)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        key_d       = key_q;
        pt_d        = pt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        core_load_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_gnt != '0) begin
                    req_ready_o = arb_gnt;
                    grant_d     = arb_idx;
                    key_d       = req_key_i[slice_lo(int'(arb_idx)) +: AES_W];
                    pt_d        = req_data_i[slice_lo(int'(arb_idx)) +: AES_W];
                    ptr_d       = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                core_load_o = 1'b1;
                cnt_d       = '0;
                state_d     = ARM;
            end
            ARM: begin
                // Testing the incremented count puts the error response
                // exactly ARM_TIMEOUT cycles after the load pulse.
                if (core_busy_i) begin
                    state_d = RUN;
                end else if (cnt_inc == CNT_W'(ARM_TIMEOUT - 1)) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!core_busy_i) begin
                    rsp_data_d = core_data_i;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                // Only the owner's ready bit matters; returning to IDLE
                // defers the next grant by one cycle.
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            // NOTE: datapath registers are reset as well because they drive outputs that must read 0 after reset.
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_key_o  = key_q;
    assign core_data_o = pt_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign grant_id_o  = grant_q;

`ifdef AES_SCHED_TRIGGER_EN
    // High for every cycle spent in ARM or RUN, i.e. from the cycle after
    // the load pulse until the core result is captured.
    logic trigger_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= (state_d == ARM) || (state_d == RUN);
        end
    end

    assign trigger_o = trigger_q;
`endif

endmodule

// File: tb/tb_aes_core_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_core_scheduler
// Directed bench for aes_core_scheduler (default build, N_REQ=2,
// ARM_TIMEOUT=4). A behavioural core model answers load pulses: busy rises
// one cycle after the load, stays high RUN_CYC cycles, then the result is
// presented. Known AES vectors return their FIPS-197 ciphertexts; any other
// job returns a simple scrambled value.
// -----------------------------------------------------------------------------
module tb_aes_core_scheduler;

    localparam int N_REQ       = 2;
    localparam int ARM_TIMEOUT = 4;
    localparam int ID_W        = 1;
    localparam int RUN_CYC     = 6;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*128-1:0]   req_key_i;
    logic [N_REQ*128-1:0]   req_data_i;
    logic [N_REQ-1:0]       rsp_valid_o;
    logic [N_REQ-1:0]       rsp_ready_i;
    logic [127:0]           rsp_data_o;
    logic                   rsp_err_o;
    logic                   core_load_o;
    logic [127:0]           core_key_o;
    logic [127:0]           core_data_o;
    logic [127:0]           core_data_i;
    logic                   core_busy_i;
    logic [ID_W-1:0]        grant_id_o;

    int n_cmp = 0;
    int n_bad = 0;
    int load_pulses = 0;
    int ready_pulses = 0;
    int grant_log[$];
    bit never_busy = 1'b0;

    always #5 clk = ~clk;

    aes_core_scheduler #(
        .N_REQ       (N_REQ),
        .ARM_TIMEOUT (ARM_TIMEOUT),
        .ID_W        (ID_W)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_key_i   (req_key_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_data_i (core_data_i),
        .core_busy_i (core_busy_i),
        .grant_id_o  (grant_id_o)
    );

    // Reference result of the core model.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        if (k == '0 && p == '0) return ZERO_CT;
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'hc3c3_5a5a_0f0f_9696_c3c3_5a5a_0f0f_9696;
    endfunction

    // Behavioural AES core.
    initial begin : core_model
        logic [127:0] m_key;
        logic [127:0] m_pt;
        bit           pending;
        int           busy_left;
        pending     = 1'b0;
        busy_left   = 0;
        m_key       = '0;
        m_pt        = '0;
        core_busy_i = 1'b0;
        core_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pending) begin
                pending     = 1'b0;
                core_busy_i = 1'b1;
                core_data_i = '1;
                busy_left   = RUN_CYC;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 0) begin
                    core_busy_i = 1'b0;
                    core_data_i = aes_ref(m_key, m_pt);
                end
            end
            if (core_load_o && !never_busy) begin
                pending = 1'b1;
                m_key   = core_key_o;
                m_pt    = core_data_o;
            end
        end
    end

    // Pulse and grant-order monitor.
    always @(negedge clk) begin
        if (core_load_o) load_pulses++;
        if (req_ready_o != '0) begin
            ready_pulses++;
            for (int i = 0; i < N_REQ; i++) if (req_ready_o[i]) grant_log.push_back(i);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [127:0] key, input logic [127:0] pt);
        req_key_i[k*128 +: 128]  = key;
        req_data_i[k*128 +: 128] = pt;
        req_valid_i[k]           = 1'b1;
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept(input int k);
        cyc();
        rsp_ready_i[k] = 1'b1;
        cyc();
        rsp_ready_i[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset_i     = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_key_i   = '0;
        req_data_i  = '0;
        repeat (3) cyc();
        @(negedge clk);
        n_cmp++; if (req_ready_o !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
        n_cmp++; if (rsp_err_o !== 1'b0 || core_load_o !== 1'b0) begin n_bad++; $display("FAIL reset_err_load: got err=%b load=%b want 0 0", rsp_err_o, core_load_o); end
        n_cmp++; if (core_key_o !== '0 || core_data_o !== '0) begin n_bad++; $display("FAIL reset_core_bus: got key=%h data=%h want 0", core_key_o, core_data_o); end
        n_cmp++; if (grant_id_o !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id_o); end
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int l0, r0;
        cyc();
        l0 = load_pulses;
        r0 = ready_pulses;
        set_req(0, '0, '0);
        wait_ready(0, ok);
        n_cmp++; if (!ok || req_ready_o !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", req_ready_o); end
        cyc();
        req_valid_i[0] = 1'b0;
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_valid_o !== 2'b01) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== ZERO_CT || rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL single_rsp_data: got %h err=%b want %h err=0", rsp_data_o, rsp_err_o, ZERO_CT); end
        n_cmp++; if (grant_id_o !== 1'b0) begin n_bad++; $display("FAIL single_grant_id: got %0d want 0", grant_id_o); end
        accept(0);
        n_cmp++; if (load_pulses - l0 != 1 || ready_pulses - r0 != 1) begin n_bad++; $display("FAIL single_pulses: got load=%0d ready=%0d want 1 1", load_pulses - l0, ready_pulses - r0); end
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== '0) begin n_bad++; $display("FAIL single_rsp_drop: got %b want 00", rsp_valid_o); end
    endtask

    task automatic test_fips();
        bit ok;
        cyc();
        set_req(1, FIPS_KEY, FIPS_PT);
        wait_ready(1, ok);
        n_cmp++; if (!ok || req_ready_o !== 2'b10) begin n_bad++; $display("FAIL fips_ready: got %b want 10", req_ready_o); end
        cyc();
        req_valid_i[1] = 1'b0;
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_valid_o !== 2'b10) begin n_bad++; $display("FAIL fips_rsp_valid: got %b want 10", rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== FIPS_CT || rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL fips_rsp_data: got %h err=%b want %h err=0", rsp_data_o, rsp_err_o, FIPS_CT); end
        n_cmp++; if (grant_id_o !== 1'b1) begin n_bad++; $display("FAIL fips_grant_id: got %0d want 1", grant_id_o); end
        accept(1);
    endtask

    task automatic test_contention();
        bit ok;
        bit order_ok;
        int own;
        logic [127:0] keys [2];
        logic [127:0] pts [2];
        keys[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        pts[0]  = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        keys[1] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        pts[1]  = 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_3c3c_c3c3;
        grant_log.delete();
        cyc();
        set_req(0, keys[0], pts[0]);
        set_req(1, keys[1], pts[1]);
        for (int j = 0; j < 4; j++) begin
            own = j % 2;
            wait_rsp(ok);
            n_cmp++; if (!ok || rsp_valid_o !== 2'(1 << own)) begin n_bad++; $display("FAIL cont_rsp_valid[%0d]: got %b want owner %0d", j, rsp_valid_o, own); end
            n_cmp++; if (rsp_data_o !== aes_ref(keys[own], pts[own])) begin n_bad++; $display("FAIL cont_rsp_data[%0d]: got %h want %h", j, rsp_data_o, aes_ref(keys[own], pts[own])); end
            n_cmp++; if (req_ready_o !== '0) begin n_bad++; $display("FAIL cont_ready_in_resp[%0d]: got %b want 00", j, req_ready_o); end
            accept(own);
            if (j == 3) req_valid_i = '0;
        end
        order_ok = (grant_log.size() == 4);
        if (order_ok) for (int j = 0; j < 4; j++) if (grant_log[j] != j % 2) order_ok = 1'b0;
        n_cmp++; if (!order_ok) begin n_bad++; $display("FAIL cont_grant_order: got %0d grants, want 4 in order 0,1,0,1", grant_log.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit stable;
        int l0;
        logic [127:0] held_data;
        logic [127:0] k2 = 128'haaaa_0000_bbbb_1111_cccc_2222_dddd_3333;
        logic [127:0] p2 = 128'h0000_0000_0000_0001_0000_0000_0000_0002;
        logic [127:0] k3 = 128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888;
        logic [127:0] p3 = 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0;
        cyc();
        set_req(0, k2, p2);
        set_req(1, k3, p3);
        wait_rsp(ok);
        held_data = rsp_data_o;
        n_cmp++; if (!ok || rsp_valid_o !== 2'b01) begin n_bad++; $display("FAIL bp_rsp_valid: got %b want 01", rsp_valid_o); end
        n_cmp++; if (held_data !== aes_ref(k2, p2)) begin n_bad++; $display("FAIL bp_rsp_data: got %h want %h", held_data, aes_ref(k2, p2)); end
        cyc();
        req_valid_i[0] = 1'b0;
        rsp_ready_i[1] = 1'b1;   // non-owner ready must be ignored
        l0 = load_pulses;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 2'b01 || rsp_data_o !== held_data || rsp_err_o !== 1'b0) stable = 1'b0;
        end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL bp_hold: got valid=%b data=%h want 01 %h", rsp_valid_o, rsp_data_o, held_data); end
        cyc();
        rsp_ready_i[1] = 1'b0;
        n_cmp++; if (load_pulses != l0) begin n_bad++; $display("FAIL bp_no_load: got %0d loads want 0", load_pulses - l0); end
        accept(0);
        wait_ready(1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_next_grant: got ready=%b want 10", req_ready_o); end
        cyc();
        req_valid_i[1] = 1'b0;
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_valid_o !== 2'b10 || rsp_data_o !== aes_ref(k3, p3)) begin n_bad++; $display("FAIL bp_second_rsp: got %b %h want 10 %h", rsp_valid_o, rsp_data_o, aes_ref(k3, p3)); end
        accept(1);
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen_load;
        int lat;
        never_busy = 1'b1;
        cyc();
        set_req(0, 128'h4444_3333_2222_1111_0000_ffff_eeee_dddd, 128'h1);
        wait_ready(0, ok);
        cyc();
        req_valid_i[0] = 1'b0;
        seen_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_load_o) begin
                seen_load = 1'b1;
                break;
            end
        end
        lat = -1;
        if (seen_load) begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (rsp_valid_o != '0) begin
                    lat = i;
                    break;
                end
            end
        end
        n_cmp++; if (lat != ARM_TIMEOUT) begin n_bad++; $display("FAIL to_latency: got %0d cycles want %0d", lat, ARM_TIMEOUT); end
        n_cmp++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b1) begin n_bad++; $display("FAIL to_err: got valid=%b err=%b want 01 1", rsp_valid_o, rsp_err_o); end
        n_cmp++; if (rsp_data_o !== '0) begin n_bad++; $display("FAIL to_data: got %h want 0", rsp_data_o); end
        accept(0);
        never_busy = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit quiet;
        bit seen_busy;
        logic [127:0] k6 = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        logic [127:0] p6 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        cyc();
        set_req(1, 128'hbeef, 128'hcafe);
        wait_ready(1, ok);
        cyc();
        req_valid_i[1] = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_busy_i) begin
                seen_busy = 1'b1;
                break;
            end
        end
        n_cmp++; if (!seen_busy) begin n_bad++; $display("FAIL rst_busy_seen: got busy=%b want 1", core_busy_i); end
        cyc();
        cyc();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid_o !== '0 || rsp_data_o !== '0 || rsp_err_o !== 1'b0 || core_load_o !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_zero: got valid=%b data=%h err=%b load=%b want all 0", rsp_valid_o, rsp_data_o, rsp_err_o, core_load_o); end
        n_cmp++; if (core_key_o !== '0 || core_data_o !== '0 || grant_id_o !== '0 || req_ready_o !== '0) begin n_bad++; $display("FAIL rst_core_zero: got key=%h data=%h grant=%0d ready=%b want all 0", core_key_o, core_data_o, grant_id_o, req_ready_o); end
        quiet = 1'b1;
        for (int i = 0; i < RUN_CYC + 6; i++) begin
            @(negedge clk);
            if (rsp_valid_o != '0 || core_load_o) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rst_no_rsp: got activity after reset, want none"); end
        cyc();
        set_req(0, k6, p6);
        set_req(1, 128'h1, 128'h2);
        @(negedge clk);
        n_cmp++; if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rst_pointer: got ready=%b want 01", req_ready_o); end
        cyc();
        req_valid_i = '0;
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_valid_o !== 2'b01 || rsp_data_o !== aes_ref(k6, p6) || rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_after_job: got %b %h err=%b want 01 %h err=0", rsp_valid_o, rsp_data_o, rsp_err_o, aes_ref(k6, p6)); end
        accept(0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_single();
        test_fips();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
